// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - shared types and constants for the UART transmit scheduler
// Contents:
//   sched_state_t : scheduler FSM states (IDLE, ISSUE, WAIT_DONE, GAP)
//   GAP_CNT_W     : width of the inter-byte guard gap counter
package uart_tx_sched_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } sched_state_t;

   localparam int GAP_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Ports:
//   req       : request vector, one bit per requester
//   ptr       : index of the previous winner; search starts at ptr+1
//   en        : when low, no grant is produced
//   grant     : one-hot grant vector
//   grant_idx : index of the granted requester
//   any_grant : high when some requester is granted
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int IDX_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_grant
);

   logic [IDX_W-1:0] cand;

   // Walk the ring from ptr+1 back around to ptr itself; the first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (en && !any_grant && req[cand]) begin
            any_grant   = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one UART byte transmitter
// Optional feature macro: UART_TX_SCHED_LOCK_EN (message lock on req_last)
// Ports:
//   clk, rst           : system clock, synchronous active-high reset
//   req_valid/ready    : per-requester byte handshake (ready is one-hot)
//   req_data           : requester i byte at bits [8i+7:8i]
//   req_last           : end-of-message marker, only used with the lock feature
//   tx_start/tx_data   : request to the transmitter with the latched byte
//   tx_busy            : transmitter busy
//   grant_id           : index of the last granted requester
//   active             : high whenever the scheduler is not in IDLE
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int GAP_CYCLES = 16,
   localparam int IDX_W = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic [IDX_W-1:0]     grant_id,
   output logic                 active
);

   sched_state_t         state;
   logic [IDX_W-1:0]     ptr;
   logic [GAP_CNT_W-1:0] gap_cnt;
   logic [NUM_REQ-1:0]   lock_mask;
   logic [NUM_REQ-1:0]   grant;
   logic [IDX_W-1:0]     win_idx;
   logic                 any_grant;
   logic [7:0]           win_data;

`ifdef UART_TX_SCHED_LOCK_EN
   logic             lock_valid;
   logic [IDX_W-1:0] lock_id;

   // While a message is in flight only its owner may be considered.
   always_comb begin
      lock_mask = '1;
      if (lock_valid) begin
         lock_mask          = '0;
         lock_mask[lock_id] = 1'b1;
      end
   end
`else
   logic unused_last;
   assign unused_last = ^req_last;
   assign lock_mask   = '1;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req_valid & lock_mask),
      .ptr       (ptr),
      .en        ((state == IDLE) && !rst),
      .grant     (grant),
      .grant_idx (win_idx),
      .any_grant (any_grant)
   );

   // Arbiter is disabled outside IDLE and during reset, so grant doubles as ready.
   assign req_ready = grant;

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            win_data = req_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= IDX_W'(NUM_REQ - 1);
         gap_cnt  <= '0;
         tx_start <= 1'b0;
         tx_data  <= '0;
         grant_id <= '0;
         active   <= 1'b0;
`ifdef UART_TX_SCHED_LOCK_EN
         lock_valid <= 1'b0;
         lock_id    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_grant) begin
                  tx_data  <= win_data;
                  grant_id <= win_idx;
                  ptr      <= win_idx;
                  tx_start <= 1'b1;
                  active   <= 1'b1;
                  state    <= ISSUE;
`ifdef UART_TX_SCHED_LOCK_EN
                  lock_valid <= !req_last[win_idx];
                  lock_id    <= win_idx;
`endif
               end
            end
            ISSUE: begin
               // Busy already high on entry still gives a one-cycle start pulse.
               if (tx_busy) begin
                  tx_start <= 1'b0;
                  state    <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  if (GAP_CYCLES > 0) begin
                     gap_cnt <= '0;
                     state   <= GAP;
                  end else begin
                     active <= 1'b0;
                     state  <= IDLE;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_CNT_W'(GAP_CYCLES - 1)) begin
                  active <= 1'b0;
                  state  <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
